// File: rtl/clkdiv_mon.sv
// Period monitor for a divided clock: measures rising-to-rising period in clk cycles,
// classifies it against P +/- TOL, and tracks lock after LOCK_N consecutive good periods.
module clkdiv_mon #(
   parameter int P      = 5,
   parameter int TOL    = 0,
   parameter int LOCK_N = 4,
   parameter int W      = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_in,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic         locked,
   output logic         err
);

   localparam int GW = $clog2(LOCK_N + 1);
   localparam logic [W-1:0]  P_W     = W'(P);
   localparam logic [W-1:0]  TOL_W   = W'(TOL);
   localparam logic [W-1:0]  TMO     = W'(4 * P);
   localparam logic [W-1:0]  CNT_MAX = {W{1'b1}};
   localparam logic [GW-1:0] LOCK_G  = GW'(LOCK_N);

   typedef enum logic [1:0] {IDLE, MEAS, CHECK, LOCK} state_t;

   function automatic logic is_good(input logic [W-1:0] meas);
      logic [W-1:0] diff;
      diff = (meas >= P_W) ? (meas - P_W) : (P_W - meas);
      return (diff <= TOL_W);
   endfunction

   logic          sync1, sync2, sync3;
   logic [1:0]    warm;
   logic          armed;
   logic [W-1:0]  cnt;
   logic [GW-1:0] gcnt;
   state_t        state;
   logic          rise;
   logic          timeout;
   logic          good;
   logic [GW-1:0] gcnt_inc;

   // Edges are armed only once the synchronizer has carried a real low level,
   // so a clk_in already high at reset release is not mistaken for a rising edge.
   assign rise     = armed & sync2 & ~sync3;
   assign timeout  = (state != IDLE) && (cnt == TMO) && !rise;
   assign good     = is_good(cnt);
   assign gcnt_inc = gcnt + GW'(1);

   // Synchronizer, edge-history flop and post-reset arming
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         warm  <= 2'd0;
         armed <= 1'b0;
      end else begin
         sync1 <= clk_in;
         sync2 <= sync1;
         sync3 <= sync2;
         if (warm != 2'd2) begin
            warm <= warm + 2'd1;
         end else begin
            warm <= warm;
         end
         if (warm == 2'd2 && !sync2) begin
            armed <= 1'b1;
         end else begin
            armed <= armed;
         end
      end
   end

   // Cycles since the last detected edge, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= {W{1'b0}};
      end else if (rise) begin
         cnt <= W'(1);
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + W'(1);
      end else begin
         cnt <= cnt;
      end
   end

   // Lock state machine with registered period/pulse/lock outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         gcnt         <= {GW{1'b0}};
         period       <= {W{1'b0}};
         period_valid <= 1'b0;
         err          <= 1'b0;
         locked       <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         err          <= 1'b0;
         case (state)
            IDLE: begin
               gcnt   <= {GW{1'b0}};
               locked <= 1'b0;
               if (rise) begin
                  state <= MEAS;
               end else begin
                  state <= IDLE;
               end
            end
            MEAS, CHECK, LOCK: begin
               if (rise) begin
                  period       <= cnt;
                  period_valid <= 1'b1;
                  if (good && state == LOCK) begin
                     state  <= LOCK;
                     locked <= 1'b1;
                  end else if (good) begin
                     // gcnt is zero on entry to MEAS, so this covers the first good period too
                     gcnt <= gcnt_inc;
                     if (gcnt_inc == LOCK_G) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                     end else begin
                        state  <= CHECK;
                        locked <= 1'b0;
                     end
                  end else begin
                     gcnt   <= {GW{1'b0}};
                     err    <= 1'b1;
                     state  <= CHECK;
                     locked <= 1'b0;
                  end
               end else if (timeout) begin
                  gcnt   <= {GW{1'b0}};
                  err    <= 1'b1;
                  state  <= IDLE;
                  locked <= 1'b0;
               end else begin
                  state  <= state;
                  locked <= locked;
               end
            end
            default: begin
               state  <= IDLE;
               gcnt   <= {GW{1'b0}};
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule
